// File: rtl/bullet_wave_scheduler.sv
// Bullet wave scheduler: arms, enables and retires bullet sprites during the attack phase,
// applies hit damage to player HP. Optional invulnerability window: define BULLET_IFRAME_EN.
module bullet_wave_scheduler #(
  parameter int NUM_BULLETS   = 4,
  parameter int BATTLE_STATE  = 1,
  parameter int WAVE_FRAMES   = 60,
  parameter int ATTACK_FRAMES = 600,
  parameter int DAMAGE        = 4,
  parameter int HP_INIT       = 20,
  parameter int IFRAMES       = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             state,
  input  logic                   frame_tick,
  input  logic [NUM_BULLETS-1:0] collision,
  output logic [NUM_BULLETS-1:0] bullet_en,
  output logic                   bullet_reset,
  output logic [3:0]             wave_idx,
  output logic [7:0]             player_hp,
  output logic                   attack_done,
  output logic                   player_dead
);

  localparam int WCW = $clog2(WAVE_FRAMES + 1);
  localparam logic [WCW-1:0] WAVE_LAST = WCW'(WAVE_FRAMES - 1);
  localparam logic [9:0]     ATK_LAST  = 10'(ATTACK_FRAMES - 1);
  localparam logic [7:0]     DMG       = 8'(DAMAGE);
  localparam logic [7:0]     HP0       = 8'(HP_INIT);
  localparam logic [3:0]     NB        = 4'(NUM_BULLETS);
  localparam logic [3:0]     BS        = 4'(BATTLE_STATE);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DONE, S_DEAD} fsm_t;

  fsm_t                   fsm;
  logic [WCW-1:0]         wave_cnt;
  logic [9:0]             atk_cnt;
  logic                   in_battle;
  logic                   iframe_clr;
  logic [NUM_BULLETS-1:0] hit_vec;
  logic                   hit;
  logic [7:0]             hp_next;
  logic                   wave_due;
  logic                   atk_due;
  logic [NUM_BULLETS-1:0] wave_bit;

`ifdef BULLET_IFRAME_EN
  localparam int ICW = $clog2(IFRAMES + 1);
  logic [ICW-1:0] iframe_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iframe_cnt <= '0;
    end else if (fsm == S_ARM) begin
      iframe_cnt <= '0;
    end else if (hit) begin
      iframe_cnt <= ICW'(IFRAMES);
    end else if (frame_tick && iframe_cnt != '0) begin
      iframe_cnt <= iframe_cnt - ICW'(1);
    end
  end

  assign iframe_clr = (iframe_cnt == '0);
`else
  assign iframe_clr = 1'b1;
`endif

  always_comb begin
    in_battle = (state == BS);
    hit_vec   = '0;
    if (fsm == S_RUN && in_battle && iframe_clr) hit_vec = collision & bullet_en;
    hit      = |hit_vec;
    hp_next  = (player_hp <= DMG) ? '0 : player_hp - DMG;
    wave_due = (wave_cnt == WAVE_LAST);
    atk_due  = (atk_cnt == ATK_LAST);
    wave_bit = '0;
    // Next bullet joins on the wave tick; once all are out, nothing more is enabled.
    if (frame_tick && wave_due && wave_idx < NB) wave_bit = NUM_BULLETS'(1) << wave_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= S_IDLE;
      bullet_en    <= '0;
      bullet_reset <= 1'b0;
      wave_idx     <= '0;
      player_hp    <= HP0;
      attack_done  <= 1'b0;
      player_dead  <= 1'b0;
      wave_cnt     <= '0;
      atk_cnt      <= '0;
    end else begin
      bullet_reset <= 1'b0;
      case (fsm)
        S_IDLE: begin
          bullet_en <= '0;
          if (in_battle && !player_dead) begin
            fsm          <= S_ARM;
            bullet_reset <= 1'b1;
            wave_cnt     <= '0;
            atk_cnt      <= '0;
            wave_idx     <= '0;
          end
        end
        S_ARM: begin
          if (!in_battle) begin
            fsm       <= S_IDLE;
            bullet_en <= '0;
          end else begin
            fsm       <= S_RUN;
            bullet_en <= NUM_BULLETS'(1);
            wave_idx  <= 4'd1;
          end
        end
        S_RUN: begin
          if (!in_battle) begin
            fsm       <= S_IDLE;
            bullet_en <= '0;
          end else if (hit && hp_next == '0) begin
            // A fatal hit outranks a simultaneous end-of-attack tick.
            fsm         <= S_DEAD;
            player_hp   <= '0;
            bullet_en   <= '0;
            player_dead <= 1'b1;
          end else begin
            if (hit) player_hp <= hp_next;
            if (frame_tick && atk_due) begin
              fsm         <= S_DONE;
              bullet_en   <= '0;
              attack_done <= 1'b1;
            end else begin
              bullet_en <= (bullet_en & ~hit_vec) | wave_bit;
              if (frame_tick) begin
                atk_cnt  <= atk_cnt + 10'd1;
                wave_cnt <= wave_due ? '0 : wave_cnt + WCW'(1);
                if (wave_due && wave_idx < NB) wave_idx <= wave_idx + 4'd1;
              end
            end
          end
        end
        S_DONE: begin
          bullet_en <= '0;
          if (!in_battle) begin
            fsm         <= S_IDLE;
            attack_done <= 1'b0;
          end
        end
        S_DEAD: begin
          bullet_en   <= '0;
          player_dead <= 1'b1;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// Randomized bench for bullet_wave_scheduler: a per-cycle reference model feeds a scoreboard
// queue that a separate monitor drains and compares against the DUT outputs.
module tb_bullet_wave_scheduler;

  localparam int NB  = 4;
  localparam int BS  = 5;
  localparam int W   = 3;
  localparam int ATK = 20;
  localparam int DMG = 6;
  localparam int HP0 = 20;
  localparam int IFR = 4;
`ifdef BULLET_IFRAME_EN
  localparam int IFR_LOAD = IFR;
`else
  localparam int IFR_LOAD = 0;
`endif

  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3, P_DEAD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    state = 4'd0;
  logic          frame_tick = 1'b0;
  logic [NB-1:0] collision = '0;
  logic [NB-1:0] bullet_en;
  logic          bullet_reset;
  logic [3:0]    wave_idx;
  logic [7:0]    player_hp;
  logic          attack_done;
  logic          player_dead;

  always #5 clk = ~clk;

  bullet_wave_scheduler #(
    .NUM_BULLETS(NB), .BATTLE_STATE(BS), .WAVE_FRAMES(W), .ATTACK_FRAMES(ATK),
    .DAMAGE(DMG), .HP_INIT(HP0), .IFRAMES(IFR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .frame_tick(frame_tick),
    .collision(collision), .bullet_en(bullet_en), .bullet_reset(bullet_reset),
    .wave_idx(wave_idx), .player_hp(player_hp), .attack_done(attack_done),
    .player_dead(player_dead)
  );

  typedef struct packed {
    logic [NB-1:0] en;
    logic          rst;
    logic [3:0]    widx;
    logic [7:0]    hp;
    logic          done;
    logic          dead;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: phase plus tick count; enabled bullets derived from how many
  // wave periods have elapsed minus the ones already struck.
  int          ph = P_IDLE;
  int          ticks = 0;
  int          widx = 0;
  int          hp = HP0;
  int          ifr = 0;
  bit [NB-1:0] killed = '0;

  always @(posedge clk) begin : model
    bit [NB-1:0] live;
    bit [NB-1:0] hitm;
    bit          loaded;
    exp_t        e;
    loaded = 1'b0;
    if (!rst_n) begin
      ph = P_IDLE; ticks = 0; widx = 0; hp = HP0; ifr = 0; killed = '0;
    end else begin
      case (ph)
        P_IDLE: if (state == BS) begin ph = P_ARM; widx = 0; end
        P_ARM: begin
          ifr = 0; loaded = 1'b1;
          if (state != BS) ph = P_IDLE;
          else begin ph = P_RUN; ticks = 0; killed = '0; widx = 1; end
        end
        P_RUN: begin
          if (state != BS) ph = P_IDLE;
          else begin
            for (int i = 0; i < NB; i++) live[i] = (i < widx) && !killed[i];
            hitm = (ifr == 0) ? (live & collision) : '0;
            if (hitm != '0) begin
              hp = (hp > DMG) ? hp - DMG : 0;
              killed |= hitm;
              ifr = IFR_LOAD; loaded = 1'b1;
            end
            if (hp == 0) ph = P_DEAD;
            else if (frame_tick) begin
              ticks++;
              if (ticks == ATK) ph = P_DONE;
              else begin
                widx = 1 + ticks / W;
                if (widx > NB) widx = NB;
              end
            end
          end
        end
        P_DONE: if (state != BS) ph = P_IDLE;
        default: ;
      endcase
      if (!loaded && frame_tick && ifr > 0) ifr--;
    end
    e.en = '0;
    if (ph == P_RUN)
      for (int i = 0; i < NB; i++) e.en[i] = (i < widx) && !killed[i];
    e.rst  = (ph == P_ARM);
    e.widx = 4'(widx);
    e.hp   = 8'(hp);
    e.done = (ph == P_DONE);
    e.dead = (ph == P_DEAD);
    sb.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: got no expected entry, required one at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("bullet_en",    int'(bullet_en),    int'(e.en));
      chk("bullet_reset", int'(bullet_reset), int'(e.rst));
      chk("wave_idx",     int'(wave_idx),     int'(e.widx));
      chk("player_hp",    int'(player_hp),    int'(e.hp));
      chk("attack_done",  int'(attack_done),  int'(e.done));
      chk("player_dead",  int'(player_dead),  int'(e.dead));
    end
  end

  int hold = 0;
  int density = 0;

  initial begin : driver
    repeat (3) @(negedge clk);
    for (int ep = 0; ep < 10; ep++) begin
      @(negedge clk);
      rst_n = 1'b0; state = 4'd0; collision = '0; frame_tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      density = ep % 3;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
        frame_tick = ($urandom_range(0, 2) == 0);
        if (hold > 0) hold--;
        else if ($urandom_range(0, 59) == 0) begin
          state = 4'(BS + $urandom_range(1, 15));
          hold  = $urandom_range(1, 6);
        end else state = 4'(BS);
        if ($urandom_range(0, 3) == 0) begin
          if (density == 0) collision = '0;
          else if (density == 1) collision = ($urandom_range(0, 15) == 0) ? NB'($urandom) : '0;
          else collision = NB'($urandom) & NB'($urandom);
        end
      end
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
